// File: rtl/key_debouncer.sv
// key_debouncer: conditions an active-low pushbutton for the single-pulse edge
// detector. The raw key is brought into the Clock domain through a flop chain.
// A four-state FSM then accepts a new level only after DEBOUNCE_CYCLES
// consecutive identical synchronized samples. Every aborted attempt is counted
// in a saturating debug counter.
module key_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BOUNCE_W        = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                key_n,
  output logic                key_db,
  output logic                changed,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = '1;

  typedef enum logic [1:0] {
    RELEASED      = 2'b00,
    CHECK_PRESS   = 2'b01,
    PRESSED       = 2'b10,
    CHECK_RELEASE = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   key_db_d;
  logic                   changed_d;
  logic [BOUNCE_W-1:0]    bounce_d;
  logic [BOUNCE_W-1:0]    bounce_inc;

  // Input synchronizer: key_n shifts in at stage 0. The FSM only ever sees
  // the last stage. Every stage idles high, which is the released level.
  // NOTE: reset is sampled on the clock edge here (no rst in the sensitivity
  // list), so every flop in this block is an ordinary synchronously-cleared flop.
  always_ff @(posedge Clock) begin
    if (!Reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The bounce counter sticks at all-ones instead of wrapping.
  assign bounce_inc = (bounce_cnt == BOUNCE_MAX) ? bounce_cnt : bounce_cnt + 1'b1;

  // State, stability counter and registered outputs.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so
  // the order of statements inside sequential blocks never changes behaviour.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      key_db     <= 1'b1;
      changed    <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_db     <= key_db_d;
      changed    <= changed_d;
      bounce_cnt <= bounce_d;
    end
  end

  // Next-state logic. A check state either counts up or aborts back to the
  // prior stable state. A reversion always wins, even on the edge that would
  // have completed the count.
  // NOTE: every signal gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    key_db_d  = key_db;
    changed_d = 1'b0;
    bounce_d  = bounce_cnt;

    case (state_q)
      RELEASED: begin
        key_db_d = 1'b1;
        if (!s) begin
          state_d = CHECK_PRESS;
          cnt_d   = CNT_ONE;
        end
      end

      CHECK_PRESS: begin
        key_db_d = 1'b1;
        if (s) begin
          state_d  = RELEASED;
          bounce_d = bounce_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          key_db_d  = 1'b0;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        key_db_d = 1'b0;
        if (s) begin
          state_d = CHECK_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end

      CHECK_RELEASE: begin
        key_db_d = 1'b0;
        if (!s) begin
          state_d  = PRESSED;
          bounce_d = bounce_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          key_db_d  = 1'b1;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // Any corrupted encoding falls back to the safe released level.
        state_d  = RELEASED;
        key_db_d = 1'b1;
      end
    endcase
  end

endmodule
